// File: rtl/am_envelope_detector_if.sv
// am_envelope_detector_if: sample-in / envelope-out valid-ready bus of the envelope detector
interface am_envelope_detector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] signal_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] envelope_o;
    logic                  ready_i;
    modport master (
        output valid_i, signal_i, ready_i,
        input  ready_o, valid_o, envelope_o
    );
    modport slave (
        input  valid_i, signal_i, ready_i,
        output ready_o, valid_o, envelope_o
    );
endinterface

// File: rtl/am_envelope_detector.sv
// am_envelope_detector: full-wave rectifier plus attack/release one-pole follower with decimated registered output
module am_envelope_detector #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 8,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 10,
    parameter int DECIM         = 1
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    am_envelope_detector_if.slave  bus
);
    localparam int AW = DATA_WIDTH - 1 + FRAC_BITS;
    localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;

    logic [DATA_WIDTH-1:0] neg;
    logic [DATA_WIDTH-2:0] mag;
    logic [AW-1:0]         target, acc, acc_next;
    logic signed [AW:0]    diff, step;
    logic [CW-1:0]         cnt;
    logic                  accept, last, valid_q;
    logic [DATA_WIDTH-1:0] env_q;

    assign bus.ready_o    = !valid_q || bus.ready_i;
    assign bus.valid_o    = valid_q;
    assign bus.envelope_o = env_q;
    assign accept         = bus.valid_i && bus.ready_o;
    assign last           = cnt == CW'(DECIM - 1);

    // rectify, saturating the most-negative sample, then step the follower toward the new target
    always_comb begin
        neg      = -bus.signal_i;
        mag      = !bus.signal_i[DATA_WIDTH-1] ? bus.signal_i[DATA_WIDTH-2:0] :
                   neg[DATA_WIDTH-1] ? '1 : neg[DATA_WIDTH-2:0];
        target   = AW'(mag) << FRAC_BITS;
        diff     = $signed({1'b0, target}) - $signed({1'b0, acc});
        step     = diff >>> (diff > 0 ? ATTACK_SHIFT : RELEASE_SHIFT);
        acc_next = AW'({1'b0, acc} + step);
    end

    // follower state and decimation counter advance only on accepted samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // registered output: load on the producing accept, drop valid once the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            env_q   <= '0;
        end else if (accept && last) begin
            valid_q <= 1'b1;
            env_q   <= {1'b0, acc_next[AW-1 -: DATA_WIDTH-1]};
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule
